// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - RV32I immediate scatter encoder, 2-stage valid/ready pipeline with word-address tagging.
// Optional macro IMM_ROUNDTRIP_CHECK_EN adds the rt_mismatch re-decode output.
module imm_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] ADDR_STEP = 32'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  fmt,
   input  logic [31:0] imm,
   input  logic [31:0] base,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic [1:0]  out_err
`ifdef IMM_ROUNDTRIP_CHECK_EN
   ,
   output logic        rt_mismatch
`endif
);

   localparam logic [2:0] FMT_I = 3'b000;
   localparam logic [2:0] FMT_S = 3'b001;
   localparam logic [2:0] FMT_B = 3'b010;
   localparam logic [2:0] FMT_J = 3'b011;
   localparam logic [2:0] FMT_U = 3'b100;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_RANGE = 2'b01;
   localparam logic [1:0] ERR_ALIGN = 2'b10;
   localparam logic [1:0] ERR_FMT   = 2'b11;

   logic        s1_valid;
   logic [2:0]  s1_fmt;
   logic [31:0] s1_imm;
   logic [31:0] s1_base;
   logic [1:0]  s1_err;
   logic        s1_adv;
   logic        s2_adv;
   logic [1:0]  err_in;
   logic [31:0] imm_mask;
   logic [31:0] imm_field;
   logic [31:0] packed_word;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // A signed value fits in N bits when every bit above N-1 matches the sign bit.
   always_comb begin
      err_in = ERR_OK;
      case (fmt)
         FMT_I, FMT_S: begin
            if (imm[31:11] != {21{imm[31]}}) err_in = ERR_RANGE;
         end
         FMT_B: begin
            if (imm[0])                           err_in = ERR_ALIGN;
            else if (imm[31:12] != {20{imm[31]}}) err_in = ERR_RANGE;
         end
         FMT_J: begin
            if (imm[0])                           err_in = ERR_ALIGN;
            else if (imm[31:20] != {12{imm[31]}}) err_in = ERR_RANGE;
         end
         FMT_U: begin
            if (imm[11:0] != 12'd0) err_in = ERR_ALIGN;
         end
         default: err_in = ERR_FMT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_fmt   <= 3'd0;
         s1_imm   <= 32'd0;
         s1_base  <= 32'd0;
         s1_err   <= ERR_OK;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_fmt  <= fmt;
            s1_imm  <= imm;
            s1_base <= base;
            s1_err  <= err_in;
         end
      end
   end

   // Illegal formats get an all-zero mask so the template passes through untouched.
   always_comb begin
      imm_mask  = 32'h0000_0000;
      imm_field = 32'h0000_0000;
      case (s1_fmt)
         FMT_I: begin
            imm_mask  = 32'hFFF0_0000;
            imm_field = {s1_imm[11:0], 20'd0};
         end
         FMT_S: begin
            imm_mask  = 32'hFE00_0F80;
            imm_field = {s1_imm[11:5], 13'd0, s1_imm[4:0], 7'd0};
         end
         FMT_B: begin
            imm_mask  = 32'hFE00_0F80;
            imm_field = {s1_imm[12], s1_imm[10:5], 13'd0, s1_imm[4:1], s1_imm[11], 7'd0};
         end
         FMT_J: begin
            imm_mask  = 32'hFFFF_F000;
            imm_field = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], 12'd0};
         end
         FMT_U: begin
            imm_mask  = 32'hFFFF_F000;
            imm_field = {s1_imm[31:12], 12'd0};
         end
         default: begin
            imm_mask  = 32'h0000_0000;
            imm_field = 32'h0000_0000;
         end
      endcase
      packed_word = (s1_base & ~imm_mask) | ((s1_err == ERR_OK) ? imm_field : 32'd0);
   end

`ifdef IMM_ROUNDTRIP_CHECK_EN
   logic [31:0] rt_imm;
   logic        rt_next;

   always_comb begin
      rt_imm = s1_imm;
      case (s1_fmt)
         FMT_I: rt_imm = {{20{packed_word[31]}}, packed_word[31:20]};
         FMT_S: rt_imm = {{20{packed_word[31]}}, packed_word[31:25], packed_word[11:7]};
         FMT_B: rt_imm = {{19{packed_word[31]}}, packed_word[31], packed_word[7],
                          packed_word[30:25], packed_word[11:8], 1'b0};
         FMT_J: rt_imm = {{11{packed_word[31]}}, packed_word[31], packed_word[19:12],
                          packed_word[20], packed_word[30:21], 1'b0};
         FMT_U: rt_imm = {packed_word[31:12], 12'd0};
         default: rt_imm = s1_imm;
      endcase
      rt_next = (s1_err == ERR_OK) && (rt_imm != s1_imm);
   end

   always_ff @(posedge clk) begin
      if (reset)                     rt_mismatch <= 1'b0;
      else if (s2_adv && s1_valid)   rt_mismatch <= rt_next;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_instr <= 32'd0;
         out_err   <= ERR_OK;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_instr <= packed_word;
            out_err   <= s1_err;
         end
      end
   end

   // Errored words still occupy an address slot so the loader image stays dense.
   always_ff @(posedge clk) begin
      if (reset)                       out_addr <= BASE_ADDR;
      else if (out_valid && out_ready) out_addr <= out_addr + ADDR_STEP;
   end

endmodule
